// File: rtl/tf530_zram_ctrl.sv
// tf530_zram_ctrl: Zorro II autoconfig fast-RAM controller for a 68030 local bus.
// Answers autoconfig at $E80000, decodes the assigned RAM window, drives the SRAM
// strobes and terminates cycles with STERM, optionally serving 4-longword cache bursts.
module tf530_zram_ctrl #(
    parameter int          RAM_MB      = 2,
    parameter int          WAIT_STATES = 0,
    parameter int          BURST_WAIT  = 0,
    parameter bit          BURST_EN    = 1'b1,
    parameter bit          CACHE_EN    = 1'b1,
    parameter logic [7:0]  PRODUCT_ID  = 8'h0A,
    parameter logic [15:0] MANUF_ID    = 16'h082C
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic [23:1] A,
    input  logic        A0,
    input  logic [1:0]  SIZ,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW20,
    input  logic        CBREQ,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    output logic        STERM,
    output logic        CBACK,
    output logic        CIIN,
    output logic        INTCYCLE,
    output logic [1:0]  BA,
    output logic [3:0]  RAMCS,
    output logic        RAMOE,
    output logic        RAMWE
);

    // Base bits compared against A[23:16]: 2 MB -> 23:21, 4 MB -> 23:22, 8 MB -> 23.
    localparam logic [7:0] BASE_MASK = (RAM_MB == 8) ? 8'h80 : (RAM_MB == 4) ? 8'hC0 : 8'hE0;
    // Autoconfig er_Type size code for the window.
    localparam logic [3:0] SIZE_NIB  = (RAM_MB == 8) ? 4'h0 : (RAM_MB == 4) ? 4'h7 : 4'h6;
    localparam logic [2:0] WS        = 3'(WAIT_STATES);
    localparam logic [1:0] BW        = 2'(BURST_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_TERM,
        S_BURST,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        configured;
    logic        shutup;
    logic [7:0]  base;
    logic [6:0]  zaddr;
    logic        ac_sel;
    logic        hit;
    logic        burst_ok;
    logic        stop_now;
    logic        final_beat;
    logic [2:0]  wcnt;
    logic [1:0]  gcnt;
    logic [1:0]  beat;
    logic [1:0]  ba_cnt;
    logic        stop_req;
    logic [3:0]  lane_en;
    logic [3:0]  rom_nib;
    logic [2:0]  lane_off;
    logic [2:0]  lane_num;
    logic        d_oe_r;
    logic [7:0]  d_out_r;
    logic        unused_bits;

    // The middle address byte and the low data nibble play no part in decoding.
    assign unused_bits = ^{A[15:8], D_IN[3:0]};

    assign zaddr      = A[7:1];
    assign ac_sel     = (A[23:16] == 8'hE8) && !AS20 && !DS20 && !configured && !shutup;
    assign hit        = configured && !AS20 && (((A[23:16] ^ base) & BASE_MASK) == 8'h00);
    assign burst_ok   = BURST_EN && !CBREQ && RW20 && (SIZ == 2'b00);
    // A burst ends after the current beat once CBREQ has been seen negated.
    assign stop_now   = stop_req || CBREQ;
    assign final_beat = (beat == 2'd3) || stop_now;

    assign INTCYCLE = !hit;
    assign CIIN     = !(hit && CACHE_EN);
    assign D_OE     = d_oe_r;
    assign D_OUT    = d_out_r;

    // Autoconfig ROM: nibble returned for the addressed register.
    always_comb begin
        rom_nib = 4'hF;
        case (zaddr)
            7'h00:   rom_nib = 4'hE;
            7'h01:   rom_nib = SIZE_NIB;
            7'h02:   rom_nib = ~PRODUCT_ID[7:4];
            7'h03:   rom_nib = ~PRODUCT_ID[3:0];
            7'h08:   rom_nib = ~MANUF_ID[15:12];
            7'h09:   rom_nib = ~MANUF_ID[11:8];
            7'h0A:   rom_nib = ~MANUF_ID[7:4];
            7'h0B:   rom_nib = ~MANUF_ID[3:0];
            default: rom_nib = 4'hF;
        endcase
    end

    // Autoconfig registers: read data/enable pipeline and base/configured/shutup writes.
    // Writing the high nibble (reg 24) configures the board, so reg 25 must be written first.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            configured <= 1'b0;
            shutup     <= 1'b0;
            base       <= 8'h00;
            d_oe_r     <= 1'b0;
            d_out_r    <= 8'hFF;
        end else begin
            d_oe_r  <= ac_sel && RW20;
            d_out_r <= (ac_sel && RW20) ? {rom_nib, 4'hF} : 8'hFF;
            if (ac_sel && !RW20) begin
                case (zaddr)
                    7'h24: begin
                        base[7:4]  <= D_IN[7:4];
                        configured <= 1'b1;
                    end
                    7'h25:   base[3:0] <= D_IN[7:4];
                    7'h26:   shutup    <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // 030 dynamic sizing: enable bytes from the A1/A0 offset for SIZ bytes, clipped at the port.
    always_comb begin
        lane_en  = 4'h0;
        lane_off = {1'b0, A[1], A0};
        case (SIZ)
            2'b01:   lane_num = 3'd1;
            2'b10:   lane_num = 3'd2;
            2'b11:   lane_num = 3'd3;
            default: lane_num = 3'd4;
        endcase
        for (int j = 0; j < 4; j++) begin
            if ((3'(j) >= lane_off) && ({1'b0, 3'(j)} < ({1'b0, lane_off} + {1'b0, lane_num}))) begin
                lane_en[3 - j] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a negated address strobe always returns to IDLE.
    always_comb begin
        state_next = state;
        if (AS20) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (hit && !DS20) state_next = (WS == 3'd0) ? S_TERM : S_WAIT;
                S_WAIT:  if (wcnt == 3'd0) state_next = S_TERM;
                S_TERM:  state_next = burst_ok ? S_BURST : S_DONE;
                S_BURST: if ((gcnt == 2'd0) && final_beat) state_next = S_DONE;
                S_DONE:  state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Wait-state, beat-gap and burst address counters.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            wcnt     <= 3'd0;
            gcnt     <= 2'd0;
            beat     <= 2'd0;
            ba_cnt   <= 2'd0;
            stop_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE: wcnt <= WS - 3'd1;
                S_WAIT: wcnt <= wcnt - 3'd1;
                S_TERM: begin
                    gcnt     <= BW;
                    beat     <= 2'd1;
                    ba_cnt   <= A[3:2] + 2'd1;
                    stop_req <= 1'b0;
                end
                S_BURST: begin
                    if (gcnt != 2'd0) begin
                        gcnt     <= gcnt - 2'd1;
                        stop_req <= stop_now;
                    end else begin
                        beat   <= beat + 2'd1;
                        ba_cnt <= ba_cnt + 2'd1;
                        gcnt   <= BW;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and SRAM strobes decoded from state; all negated while AS20 is high.
    always_comb begin
        STERM = 1'b1;
        CBACK = 1'b1;
        RAMOE = 1'b1;
        RAMWE = 1'b1;
        RAMCS = 4'hF;
        BA    = A[3:2];
        if (!AS20) begin
            case (state)
                S_WAIT: begin
                    RAMCS = ~lane_en;
                    RAMOE = !RW20;
                    RAMWE = RW20;
                end
                S_TERM: begin
                    RAMCS = ~lane_en;
                    RAMOE = !RW20;
                    RAMWE = RW20;
                    STERM = 1'b0;
                    CBACK = !burst_ok;
                end
                S_BURST: begin
                    RAMCS = 4'h0;
                    RAMOE = 1'b0;
                    BA    = ba_cnt;
                    STERM = (gcnt != 2'd0);
                    CBACK = (gcnt == 2'd0) && final_beat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tf530_zram_ctrl.sv
// Directed bench for tf530_zram_ctrl: 2 MB window, 2 wait states, 1 burst gap cycle.
module tb_tf530_zram_ctrl;

    logic        CLKCPU = 1'b0;
    logic        RESET;
    logic [23:1] A;
    logic        A0;
    logic [1:0]  SIZ;
    logic        AS20;
    logic        DS20;
    logic        RW20;
    logic        CBREQ;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        STERM;
    logic        CBACK;
    logic        CIIN;
    logic        INTCYCLE;
    logic [1:0]  BA;
    logic [3:0]  RAMCS;
    logic        RAMOE;
    logic        RAMWE;

    int checks = 0;
    int errors = 0;
    int we_cnt;
    int st_cnt;

    // Full burst from BA=2 with one gap cycle per beat, edges 1..10 after the request.
    logic exp_st [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_cb [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_ba [10] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};

    tf530_zram_ctrl #(
        .RAM_MB(2),
        .WAIT_STATES(2),
        .BURST_WAIT(1),
        .BURST_EN(1'b1),
        .CACHE_EN(1'b1),
        .PRODUCT_ID(8'h0A),
        .MANUF_ID(16'h082C)
    ) dut (
        .CLKCPU(CLKCPU),
        .RESET(RESET),
        .A(A),
        .A0(A0),
        .SIZ(SIZ),
        .AS20(AS20),
        .DS20(DS20),
        .RW20(RW20),
        .CBREQ(CBREQ),
        .D_IN(D_IN),
        .D_OUT(D_OUT),
        .D_OE(D_OE),
        .STERM(STERM),
        .CBACK(CBACK),
        .CIIN(CIIN),
        .INTCYCLE(INTCYCLE),
        .BA(BA),
        .RAMCS(RAMCS),
        .RAMOE(RAMOE),
        .RAMWE(RAMWE)
    );

    always #5 CLKCPU = ~CLKCPU;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKCPU);
        #2;
    endtask

    task automatic set_addr(input logic [23:0] addr);
        A  = addr[23:1];
        A0 = addr[0];
    endtask

    task automatic bus_idle();
        AS20  = 1'b1;
        DS20  = 1'b1;
        RW20  = 1'b1;
        CBREQ = 1'b1;
        SIZ   = 2'b00;
    endtask

    task automatic start(input logic [23:0] addr, input logic [1:0] siz, input logic rw, input logic cbreq);
        set_addr(addr);
        SIZ   = siz;
        RW20  = rw;
        CBREQ = cbreq;
        AS20  = 1'b0;
        DS20  = 1'b0;
    endtask

    task automatic ac_read(input string tag, input logic [23:0] addr, input logic [7:0] exp_out);
        start(addr, 2'b00, 1'b1, 1'b1);
        #1;
        chk1({tag, "_oe_pre"}, D_OE, 1'b0);
        tick();
        chk1({tag, "_oe"}, D_OE, 1'b1);
        chk8({tag, "_dout"}, D_OUT, exp_out);
        chk1({tag, "_int"}, INTCYCLE, 1'b1);
        bus_idle();
        tick();
        chk1({tag, "_oe_post"}, D_OE, 1'b0);
    endtask

    task automatic ac_write(input logic [23:0] addr, input logic [7:0] data);
        start(addr, 2'b00, 1'b0, 1'b1);
        D_IN = data;
        tick();
        bus_idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        RESET = 1'b0;
        D_IN  = 8'h00;
        bus_idle();
        set_addr(24'h000008);
        tick();
        tick();
        chk1("rst_sterm", STERM, 1'b1);
        chk1("rst_cback", CBACK, 1'b1);
        chk1("rst_ramoe", RAMOE, 1'b1);
        chk1("rst_ramwe", RAMWE, 1'b1);
        chk1("rst_int", INTCYCLE, 1'b1);
        chk8("rst_ramcs", 8'(RAMCS), 8'h0F);
        chk1("rst_doe", D_OE, 1'b0);
        chk8("rst_dout", D_OUT, 8'hFF);
        chk8("rst_ba", 8'(BA), 8'h02);
        chk1("rst_ciin", CIIN, 1'b1);
        RESET = 1'b1;
        tick();

        // Autoconfig ROM reads
        ac_read("ac00", 24'hE80000, 8'hEF);
        ac_read("ac01", 24'hE80002, 8'h6F);
        ac_read("ac02", 24'hE80004, 8'hFF);
        ac_read("ac03", 24'hE80006, 8'h5F);
        ac_read("ac04", 24'hE80008, 8'hFF);
        ac_read("ac09", 24'hE80012, 8'h7F);
        ac_read("ac0b", 24'hE80016, 8'h3F);

        // Unconfigured board does not claim RAM space
        start(24'h200000, 2'b00, 1'b1, 1'b1);
        #1;
        chk1("uncfg_int", INTCYCLE, 1'b1);
        bus_idle();
        tick();

        // Configure base $20
        ac_write(24'hE80048, 8'h20);
        start(24'hE80000, 2'b00, 1'b1, 1'b1);
        tick();
        chk1("cfg_ac_off", D_OE, 1'b0);
        bus_idle();
        tick();

        // Long read at $200000, no burst: STERM at edge 3
        start(24'h200000, 2'b00, 1'b1, 1'b1);
        #1;
        chk1("lr_int", INTCYCLE, 1'b0);
        chk1("lr_ciin", CIIN, 1'b0);
        chk1("lr_st0", STERM, 1'b1);
        tick();
        chk1("lr_st1", STERM, 1'b1);
        chk1("lr_oe1", RAMOE, 1'b0);
        chk8("lr_cs1", 8'(RAMCS), 8'h00);
        chk1("lr_we1", RAMWE, 1'b1);
        tick();
        chk1("lr_st2", STERM, 1'b1);
        tick();
        chk1("lr_st3", STERM, 1'b0);
        chk1("lr_cb3", CBACK, 1'b1);
        tick();
        chk1("lr_st4", STERM, 1'b1);
        chk1("lr_oe4", RAMOE, 1'b1);
        chk8("lr_cs4", 8'(RAMCS), 8'h0F);
        chk1("lr_int4", INTCYCLE, 1'b0);
        bus_idle();
        #1;
        chk1("lr_int5", INTCYCLE, 1'b1);
        tick();

        // Window boundaries
        set_addr(24'h3FFFFE);
        AS20 = 1'b0;
        #1;
        chk1("top_int", INTCYCLE, 1'b0);
        set_addr(24'h400000);
        #1;
        chk1("above_int", INTCYCLE, 1'b1);
        chk1("above_ciin", CIIN, 1'b1);
        set_addr(24'h1FFFFE);
        #1;
        chk1("below_int", INTCYCLE, 1'b1);
        bus_idle();
        tick();

        // Byte write at offset 1
        start(24'h200001, 2'b01, 1'b0, 1'b1);
        we_cnt = 0;
        st_cnt = 0;
        tick();
        chk8("bw_cs", 8'(RAMCS), 8'h0B);
        chk1("bw_oe", RAMOE, 1'b1);
        if (RAMWE == 1'b0) we_cnt++;
        if (STERM == 1'b0) st_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (RAMWE == 1'b0) we_cnt++;
            if (STERM == 1'b0) st_cnt++;
        end
        chk8("bw_we_cycles", 8'(we_cnt), 8'd3);
        chk8("bw_sterm_pulses", 8'(st_cnt), 8'd1);
        bus_idle();
        tick();

        // Lane decode: word at offset 2, 3-byte at offset 1
        start(24'h200002, 2'b10, 1'b1, 1'b1);
        tick();
        chk8("word_cs", 8'(RAMCS), 8'h0C);
        bus_idle();
        #1;
        chk8("word_cs_as_off", 8'(RAMCS), 8'h0F);
        tick();
        start(24'h200001, 2'b11, 1'b1, 1'b1);
        tick();
        chk8("tri_cs", 8'(RAMCS), 8'h08);
        bus_idle();
        tick();

        // Full burst from BA=2
        start(24'h200008, 2'b00, 1'b1, 1'b0);
        st_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1($sformatf("burst_sterm_e%0d", i + 1), STERM, exp_st[i]);
            chk1($sformatf("burst_cback_e%0d", i + 1), CBACK, exp_cb[i]);
            chk8($sformatf("burst_ba_e%0d", i + 1), 8'(BA), 8'(exp_ba[i]));
            if (i == 4) chk8("burst_cs", 8'(RAMCS), 8'h00);
            if (STERM == 1'b0) st_cnt++;
        end
        chk8("burst_pulses", 8'(st_cnt), 8'd4);
        chk8("burst_done_cs", 8'(RAMCS), 8'h0F);
        bus_idle();
        tick();

        // Burst cut short: CBREQ negated during beat 2
        start(24'h200008, 2'b00, 1'b1, 1'b0);
        st_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (STERM == 1'b0) st_cnt++;
        end
        CBREQ = 1'b1;
        #1;
        chk1("stop_cb_gap", CBACK, 1'b0);
        tick();
        chk1("stop_st_b2", STERM, 1'b0);
        chk1("stop_cb_b2", CBACK, 1'b1);
        chk8("stop_ba_b2", 8'(BA), 8'h00);
        if (STERM == 1'b0) st_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (STERM == 1'b0) st_cnt++;
        end
        chk8("stop_pulses", 8'(st_cnt), 8'd3);
        bus_idle();
        tick();

        // AS20 negated mid-burst
        start(24'h200008, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk1("abort_st5", STERM, 1'b0);
        bus_idle();
        #1;
        chk8("abort_cs_now", 8'(RAMCS), 8'h0F);
        chk1("abort_st_now", STERM, 1'b1);
        tick();
        chk8("abort_cs", 8'(RAMCS), 8'h0F);
        chk1("abort_oe", RAMOE, 1'b1);
        chk1("abort_cb", CBACK, 1'b1);
        chk8("abort_ba", 8'(BA), 8'h02);
        start(24'h200008, 2'b00, 1'b1, 1'b1);
        tick();
        tick();
        chk1("restart_st2", STERM, 1'b1);
        tick();
        chk1("restart_st3", STERM, 1'b0);
        bus_idle();
        tick();

        // Reset during WAIT
        start(24'h200000, 2'b00, 1'b1, 1'b1);
        tick();
        RESET = 1'b0;
        st_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (STERM == 1'b0) st_cnt++;
        end
        chk8("rstwait_pulses", 8'(st_cnt), 8'd0);
        chk1("rstwait_int", INTCYCLE, 1'b1);
        RESET = 1'b1;
        bus_idle();
        tick();

        // Shut-up disables autoconfig
        ac_write(24'hE8004C, 8'h00);
        start(24'hE80000, 2'b00, 1'b1, 1'b1);
        tick();
        chk1("shut_oe1", D_OE, 1'b0);
        chk8("shut_dout", D_OUT, 8'hFF);
        tick();
        chk1("shut_oe2", D_OE, 1'b0);
        bus_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
